// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types and helpers for the 4-floor elevator controller.
//   state_t      - controller FSM states
//   UP / DOWN    - travel direction encoding
//   NUM_FLOORS   - number of served floors
//   floor_calls  - folds the three pending vectors into one bit per floor
//   above_mask / below_mask / floor_hot - per-floor masks relative to a floor
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  localparam int         NUM_FLOORS   = 4;
  localparam logic [1:0] FLOOR_BOTTOM = 2'd0;

  // up calls exist for floors 0-2 (bit i = floor i),
  // down calls for floors 1-3 (bit i = floor i+1)
  function automatic logic [NUM_FLOORS-1:0] floor_calls(input logic [2:0] up,
                                                        input logic [2:0] down,
                                                        input logic [3:0] car);
    return car | {1'b0, up} | {down, 1'b0};
  endfunction

  function automatic logic [3:0] floor_hot(input logic [1:0] p);
    return 4'b0001 << p;
  endfunction

  function automatic logic [3:0] above_mask(input logic [1:0] p);
    return 4'b1110 << p;
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] p);
    return ~(4'b1111 << p);
  endfunction

endpackage

// File: rtl/request_table.sv
// request_table: sticky pending-request registers for hall and car calls.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   button_up/down/in          - button pulses (same indexing as pending_*)
//   position, door_open        - car floor and door status
//   clr_valid, clr_floor       - clear requests at clr_floor this edge
//   clr_up, clr_down           - which hall calls at clr_floor to clear
//   pending_up/down/in         - latched requests
//   here, above, below         - any pending request at / above / below position
//   press_here                 - a button for the current floor while the door is open
module request_table
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [3:0] button_in,
  input  logic [1:0] position,
  input  logic       door_open,
  input  logic       clr_valid,
  input  logic [1:0] clr_floor,
  input  logic       clr_up,
  input  logic       clr_down,
  output logic [2:0] pending_up,
  output logic [2:0] pending_down,
  output logic [3:0] pending_in,
  output logic       here,
  output logic       above,
  output logic       below,
  output logic       press_here
);

  logic [3:0] pos_hot;
  logic [3:0] hold_hot;
  logic [3:0] clr_hot;
  logic [2:0] clr_up_hot;
  logic [2:0] clr_down_hot;
  logic [3:0] calls;

  assign pos_hot      = floor_hot(position);
  // presses for the floor the open door is serving are absorbed, not latched
  assign hold_hot     = door_open ? pos_hot : 4'b0000;
  assign clr_hot      = clr_valid ? floor_hot(clr_floor) : 4'b0000;
  assign clr_up_hot   = clr_up   ? clr_hot[2:0] : 3'b000;
  assign clr_down_hot = clr_down ? clr_hot[3:1] : 3'b000;

  assign press_here = |(floor_calls(button_up, button_down, button_in) & hold_hot);

  assign calls = floor_calls(pending_up, pending_down, pending_in);
  assign here  = |(calls & pos_hot);
  assign above = |(calls & above_mask(position));
  assign below = |(calls & below_mask(position));

  // clear is applied after set so the stopping floor's clear wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_up   <= '0;
      pending_down <= '0;
      pending_in   <= '0;
    end else begin
      pending_in   <= (pending_in   | (button_in   & ~hold_hot))      & ~clr_hot;
      pending_up   <= (pending_up   | (button_up   & ~hold_hot[2:0])) & ~clr_up_hot;
      pending_down <= (pending_down | (button_down & ~hold_hot[3:1])) & ~clr_down_hot;
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// elevator_controller: sequencing FSM for the 4-floor elevator car.
// Parameters: FLOOR_TICKS (cycles per floor), DOOR_TICKS (door dwell cycles).
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   button_up/down/in                - hall and car button pulses
//   position                         - current floor 0-3
//   moving_up, moving_down, door_open - registered status, at most one high
//   pending_up/down/in               - latched requests
//
// state     | meaning
// IDLE      | parked, re-evaluating requests every cycle
// MOVE_UP   | travelling up one floor, timer counting
// MOVE_DOWN | travelling down one floor, timer counting
// DOOR_OPEN | door open at position, dwell timer counting
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int FLOOR_TICKS = 4,
  parameter int DOOR_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] button_up,
  input  logic [2:0] button_down,
  input  logic [3:0] button_in,
  output logic [1:0] position,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [2:0] pending_up,
  output logic [2:0] pending_down,
  output logic [3:0] pending_in
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  state_t        state, nxt_state, dec_state;
  logic          dir, dec_dir, door_dir;
  logic [TW-1:0] timer;
  logic          timer_done, decide, travel_step, enter_door, further;
  logic [1:0]    next_floor, door_floor;
  logic [3:0]    calls, up_at, down_at;
  logic          stop_up, stop_down;
  logic          here, above, below, press_here;
  logic          clr_up, clr_down;

  request_table u_requests (
    .clk          (clk),
    .reset        (reset),
    .button_up    (button_up),
    .button_down  (button_down),
    .button_in    (button_in),
    .position     (position),
    .door_open    (door_open),
    .clr_valid    (enter_door),
    .clr_floor    (door_floor),
    .clr_up       (clr_up),
    .clr_down     (clr_down),
    .pending_up   (pending_up),
    .pending_down (pending_down),
    .pending_in   (pending_in),
    .here         (here),
    .above        (above),
    .below        (below),
    .press_here   (press_here)
  );

  assign calls   = floor_calls(pending_up, pending_down, pending_in);
  assign up_at   = {1'b0, pending_up};
  assign down_at = {pending_down, 1'b0};

  // directional-collect decision at the current floor
  always_comb begin
    dec_state = IDLE;
    dec_dir   = dir;
    if (here) begin
      dec_state = DOOR_OPEN;
      // a lone opposite-direction hall call here would never be cleared under
      // the current dir, so turn around and let this door opening answer it
      if (!pending_in[position] &&
          ((dir == UP) ? !up_at[position] : !down_at[position]))
        dec_dir = ~dir;
    end else if (dir == UP) begin
      if (above) begin
        dec_state = MOVE_UP;
      end else if (below) begin
        dec_state = MOVE_DOWN;
        dec_dir   = DOWN;
      end
    end else begin
      if (below) begin
        dec_state = MOVE_DOWN;
      end else if (above) begin
        dec_state = MOVE_UP;
        dec_dir   = UP;
      end
    end
  end

  assign timer_done  = (timer == '0);
  assign travel_step = ((state == MOVE_UP) || (state == MOVE_DOWN)) && timer_done;
  assign decide      = (state == IDLE) ||
                       ((state == DOOR_OPEN) && !press_here && timer_done);
  assign next_floor  = (state == MOVE_DOWN) ? position - 2'd1 : position + 2'd1;

  assign stop_up   = pending_in[next_floor] | up_at[next_floor] |
                     ~|(calls & above_mask(next_floor));
  assign stop_down = pending_in[next_floor] | down_at[next_floor] |
                     ~|(calls & below_mask(next_floor));

  always_comb begin
    nxt_state = state;
    if (decide)
      nxt_state = dec_state;
    else if (travel_step && ((state == MOVE_UP) ? stop_up : stop_down))
      nxt_state = DOOR_OPEN;
  end

  // door entry clears requests at the floor in the same edge it opens
  assign enter_door = (nxt_state == DOOR_OPEN) && (decide || travel_step);
  assign door_floor = travel_step ? next_floor : position;
  assign door_dir   = decide ? dec_dir : dir;
  assign further    = |(calls & ((door_dir == UP) ? above_mask(door_floor)
                                                  : below_mask(door_floor)));
  assign clr_up     = (door_dir == UP)   | ~further;
  assign clr_down   = (door_dir == DOWN) | ~further;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= UP;
      timer       <= '0;
      position    <= FLOOR_BOTTOM;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state       <= nxt_state;
      moving_up   <= (nxt_state == MOVE_UP);
      moving_down <= (nxt_state == MOVE_DOWN);
      door_open   <= (nxt_state == DOOR_OPEN);
      if (decide)
        dir <= dec_dir;
      if (travel_step)
        position <= next_floor;
      if (decide || travel_step || press_here) begin
        case (nxt_state)
          DOOR_OPEN:         timer <= DOOR_LOAD;
          MOVE_UP, MOVE_DOWN: timer <= FLOOR_LOAD;
          default:           timer <= '0;
        endcase
      end else if (!timer_done) begin
        timer <= timer - TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
module tb_elevator_controller;
  import elevator_pkg::*;

  localparam int S_POS  = 0;
  localparam int S_UP   = 1;
  localparam int S_DN   = 2;
  localparam int S_DOOR = 3;
  localparam int S_PUP  = 4;
  localparam int S_PDN  = 5;
  localparam int S_PIN  = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] button_up = '0;
  logic [2:0] button_down = '0;
  logic [3:0] button_in = '0;
  logic [1:0] position;
  logic       moving_up, moving_down, door_open;
  logic [2:0] pending_up, pending_down;
  logic [3:0] pending_in;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [3:0] val;
  } exp_t;
  exp_t sb[$];

  elevator_controller #(.FLOOR_TICKS(4), .DOOR_TICKS(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .button_up    (button_up),
    .button_down  (button_down),
    .button_in    (button_in),
    .position     (position),
    .moving_up    (moving_up),
    .moving_down  (moving_down),
    .door_open    (door_open),
    .pending_up   (pending_up),
    .pending_down (pending_down),
    .pending_in   (pending_in)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] sample(input int sel);
    case (sel)
      S_POS:   return {2'b00, position};
      S_UP:    return {3'b000, moving_up};
      S_DN:    return {3'b000, moving_down};
      S_DOOR:  return {3'b000, door_open};
      S_PUP:   return {1'b0, pending_up};
      S_PDN:   return {1'b0, pending_down};
      default: return pending_in;
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      S_POS:   return "position";
      S_UP:    return "moving_up";
      S_DN:    return "moving_down";
      S_DOOR:  return "door_open";
      S_PUP:   return "pending_up";
      S_PDN:   return "pending_down";
      default: return "pending_in";
    endcase
  endfunction

  task automatic push_exp(input int cyc, input int sel, input logic [3:0] val);
    exp_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    button_up = '0;
    button_down = '0;
    button_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 7; s++) begin
      push_exp(0, s, 4'h0);
      push_exp(1, s, 4'h0);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL reset c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL reset: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  task automatic test_travel();
    do_reset();
    push_exp(1, S_PIN, 4'b0100);
    push_exp(1, S_UP, 4'h0);
    for (int c = 2; c <= 9; c++) push_exp(c, S_UP, 4'h1);
    push_exp(5, S_POS, 4'd0);
    push_exp(6, S_POS, 4'd1);
    push_exp(9, S_POS, 4'd1);
    push_exp(10, S_POS, 4'd2);
    push_exp(9, S_DOOR, 4'h0);
    for (int c = 10; c <= 12; c++) push_exp(c, S_DOOR, 4'h1);
    push_exp(13, S_DOOR, 4'h0);
    push_exp(10, S_PIN, 4'h0);
    push_exp(10, S_UP, 4'h0);
    push_exp(13, S_UP, 4'h0);
    for (int c = 0; c < 15; c++) begin
      button_in = (c == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL travel c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    button_in = '0;
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL travel: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  task automatic test_same_floor();
    do_reset();
    push_exp(1, S_PIN, 4'b0001);
    push_exp(1, S_DOOR, 4'h0);
    push_exp(2, S_PIN, 4'h0);
    push_exp(2, S_UP, 4'h0);
    for (int c = 2; c <= 4; c++) begin
      push_exp(c, S_DOOR, 4'h1);
      push_exp(c, S_POS, 4'd0);
    end
    push_exp(5, S_DOOR, 4'h0);
    push_exp(5, S_POS, 4'd0);
    for (int c = 0; c < 7; c++) begin
      button_in = (c == 0) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL same_floor c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    button_in = '0;
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL same_floor: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  task automatic test_door_reload();
    do_reset();
    for (int c = 10; c <= 14; c++) push_exp(c, S_DOOR, 4'h1);
    push_exp(15, S_DOOR, 4'h0);
    push_exp(12, S_PIN, 4'h0);
    push_exp(15, S_PIN, 4'h0);
    push_exp(14, S_POS, 4'd2);
    push_exp(15, S_POS, 4'd2);
    push_exp(15, S_UP, 4'h0);
    for (int c = 0; c < 17; c++) begin
      button_in = (c == 0 || c == 11) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL door_reload c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    button_in = '0;
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL door_reload: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  // presses land on the arrival edge at floor 2: the floor-2 press is eaten
  // by the clear, the floor-0 car call and floor-1 up call latch
  task automatic test_same_edge_clear();
    do_reset();
    push_exp(10, S_PIN, 4'b0001);
    push_exp(10, S_PUP, 4'b0010);
    push_exp(10, S_DOOR, 4'h1);
    push_exp(13, S_DN, 4'h1);
    push_exp(16, S_POS, 4'd2);
    push_exp(17, S_POS, 4'd1);
    push_exp(20, S_DN, 4'h1);
    push_exp(21, S_POS, 4'd0);
    push_exp(21, S_DOOR, 4'h1);
    push_exp(21, S_PIN, 4'h0);
    push_exp(22, S_PUP, 4'b0010);
    push_exp(24, S_UP, 4'h1);
    push_exp(27, S_POS, 4'd0);
    push_exp(28, S_POS, 4'd1);
    push_exp(28, S_DOOR, 4'h1);
    push_exp(28, S_PUP, 4'h0);
    push_exp(31, S_DOOR, 4'h0);
    for (int c = 0; c < 33; c++) begin
      button_in = (c == 0) ? 4'b0100 : (c == 9) ? 4'b0101 : 4'b0000;
      button_up = (c == 9) ? 3'b010 : 3'b000;
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL same_edge c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    button_in = '0;
    button_up = '0;
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL same_edge: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  // scenario 0: at floor 1 heading up, car calls 3 and 0 together
  // scenario 1: at floor 0, car call 3 plus down call at floor 2
  task automatic test_direction_collect();
    int   door_q[$];
    int   got;
    int   c;
    logic prev_door;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      if (s == 0) begin
        button_in = 4'b0010;
        @(posedge clk); #1;
        button_in = 4'b0000;
        repeat (12) @(posedge clk);
        #1;
        tests_run++;
        if (position !== 2'd1 || door_open !== 1'b0 || moving_up !== 1'b0) begin
          tests_failed++;
          $display("FAIL collect_setup: position %0d door %0b up %0b, need floor 1 parked",
                   position, door_open, moving_up);
        end
        button_in = 4'b1001;
        door_q = '{3, 0};
      end else begin
        button_in = 4'b1000;
        button_down = 3'b010;
        door_q = '{3, 2};
      end
      @(posedge clk); #1;
      button_in = '0;
      button_down = '0;
      prev_door = 1'b0;
      c = 0;
      while ((door_q.size() > 0 || door_open || moving_up || moving_down) && c < 80) begin
        @(negedge clk);
        if (door_open && !prev_door) begin
          tests_run++;
          if (door_q.size() == 0) begin
            tests_failed++;
            $display("FAIL collect%0d stop: door opened at floor %0d, no stop expected",
                     s, position);
          end else begin
            got = door_q.pop_front();
            if (position !== got[1:0]) begin
              tests_failed++;
              $display("FAIL collect%0d stop: door opened at floor %0d, expected floor %0d",
                       s, position, got);
            end
          end
        end
        prev_door = door_open;
        @(posedge clk); #1;
        c++;
      end
      tests_run++;
      if (door_q.size() != 0 || door_open || moving_up || moving_down) begin
        tests_failed++;
        $display("FAIL collect%0d timeout: %0d stops outstanding after %0d cycles",
                 s, door_q.size(), c);
      end
      tests_run++;
      if ({pending_up, pending_down, pending_in} !== 10'h000) begin
        tests_failed++;
        $display("FAIL collect%0d pending: up %b down %b in %b, expected all zero",
                 s, pending_up, pending_down, pending_in);
      end
      door_q.delete();
    end
  endtask

  task automatic test_reset_midtravel();
    do_reset();
    push_exp(6, S_POS, 4'd1);
    push_exp(7, S_UP, 4'h1);
    push_exp(7, S_PUP, 4'b0100);
    for (int s = 0; s < 7; s++) push_exp(8, s, 4'h0);
    push_exp(9, S_UP, 4'h0);
    push_exp(9, S_POS, 4'd0);
    push_exp(9, S_PIN, 4'h0);
    for (int c = 0; c < 11; c++) begin
      button_in = (c == 0) ? 4'b1000 : 4'b0000;
      button_up = (c == 3) ? 3'b100 : 3'b000;
      reset = (c == 7);
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == c) begin
          tests_run++;
          if (sample(sb[i].sel) !== sb[i].val) begin
            tests_failed++;
            $display("FAIL reset_mid c%0d %s: got %0h expected %0h", c, sig_name(sb[i].sel),
                     sample(sb[i].sel), sb[i].val);
          end
          sb.delete(i);
        end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    button_in = '0;
    button_up = '0;
    foreach (sb[i]) begin
      tests_run++; tests_failed++;
      $display("FAIL reset_mid: check at cycle %0d never reached", sb[i].cyc);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_travel();
    test_same_floor();
    test_door_reload();
    test_same_edge_clear();
    test_direction_collect();
    test_reset_midtravel();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
